// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and index/word types for the CPU register file
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 16;
  localparam int REGFILE_ADDR_W   = 3;
  localparam int REGFILE_NUM_REGS = 8;

  typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port of the register file
// Write-to-read forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               rd_idx,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               rd_data
);

`ifdef REGFILE_BYPASS_EN
  // wr_en arrives already qualified by reset, so forwarding is quiet while in reset
  always_comb begin
    rd_data = regs[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_data = wr_data;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_idx, wr_data};
  assign rd_data       = regs[rd_idx];
`endif

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two combinational reads, one synchronous write
// Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
    $error("register_file: NUM_REGS must equal 2**ADDR_W");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic                            wr_en;

  assign wr_en = reg_write & rst_n;

  always_comb begin
    regs_d = regs_q;
    if (reg_write) begin
      regs_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_read_port1 (
    .regs   (regs_q),
    .rd_idx (read_reg1),
    .wr_en  (wr_en),
    .wr_idx (write_reg),
    .wr_data(write_data),
    .rd_data(read_data1)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_read_port2 (
    .regs   (regs_q),
    .rd_idx (read_reg2),
    .wr_en  (wr_en),
    .wr_idx (write_reg),
    .wr_data(write_data),
    .rd_data(read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file against an array model
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        reg_write;
  logic [15:0] read_data1;
  logic [15:0] read_data2;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  logic [15:0] model [8];

  register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: registers are plain storage, cleared by reset, updated at the rising edge.
  always @(negedge rst_n) begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  end

  always @(posedge clk) begin
    if (rst_n && reg_write) model[write_reg] = write_data;
  end

  function automatic logic [15:0] expect_rd(input logic [2:0] idx);
    if (!rst_n) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && (idx == write_reg)) return write_data;
`endif
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rd1", read_data1, expect_rd(read_reg1));
      chk("model_rd2", read_data2, expect_rd(read_reg2));
    end
  end

  task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2);
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #1 cmp_en = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset contents: every index reads zero on both ports
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
      #2;
      chk("reset_rd1", read_data1, 16'h0000);
      chk("reset_rd2", read_data2, 16'h0000);
    end

    // Register 0 is writable like any other
    @(posedge clk); #1 drive(1'b1, 3'd0, 16'h1234, 3'd0, 3'd1);
    @(posedge clk); #1 drive(1'b1, 3'd1, 16'h5678, 3'd0, 3'd1);
    @(posedge clk); #1 drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd1);
    #2;
    chk("reg0_write", read_data1, 16'h1234);
    chk("reg1_write", read_data2, 16'h5678);

    // Disabled write leaves reg 1 alone
    @(posedge clk); #1 drive(1'b0, 3'd1, 16'hFFFF, 3'd1, 3'd1);
    repeat (3) @(posedge clk);
    #3 chk("write_disable", read_data1, 16'h5678);

    // Both ports on the same index
    drive(1'b0, 3'd1, 16'hFFFF, 3'd0, 3'd0);
    #1;
    chk("same_idx_rd1", read_data1, 16'h1234);
    chk("same_idx_rd2", read_data2, 16'h1234);

    // Same-cycle read/write of reg 2
    @(posedge clk); #1 drive(1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd0);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("rw_before_edge", read_data1, 16'hBEEF);
`else
    chk("rw_before_edge", read_data1, 16'h0000);
`endif
    chk("rw_other_port", read_data2, 16'h1234);
    @(posedge clk); #1 drive(1'b0, 3'd2, 16'h0000, 3'd2, 3'd0);
    #2 chk("rw_after_edge", read_data1, 16'hBEEF);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
        #2 rst_n = 1'b1;
      end
    end

    // Mid-operation reset while a write is pending
    @(posedge clk); #1 drive(1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd4);
    @(posedge clk); #1 drive(1'b1, 3'd4, 16'h0F0F, 3'd3, 3'd4);
    #2 chk("pre_reset_r3", read_data1, 16'hAAAA);
    @(posedge clk); #1 drive(1'b1, 3'd3, 16'h5555, 3'd3, 3'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_r3", read_data1, 16'h0000);
    chk("async_rst_r4", read_data2, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_r3", read_data1, 16'h0000);
    chk("rst_hold_r4", read_data2, 16'h0000);
    drive(1'b0, 3'd3, 16'h0000, 3'd3, 3'd4);
    #1 rst_n = 1'b1;
    @(posedge clk); #3;
    chk("post_rst_r3", read_data1, 16'h0000);
    chk("post_rst_r4", read_data2, 16'h0000);

    @(posedge clk); #1 cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
